// File: rtl/if_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response channel plus the
// decoded-side instruction stream. master = fetch unit, slave = memory/decode side.
interface if_fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            imem_rsp_err;
  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_pc;
  logic [31:0]     if_instr;
  logic            if_err;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data, imem_rsp_err,
    output if_valid, if_pc, if_instr, if_err,
    input  if_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data, imem_rsp_err,
    input  if_valid, if_pc, if_instr, if_err,
    output if_ready
  );
endinterface

// File: rtl/if_fetch_unit.sv
// RV32I instruction fetch: credit-limited in-order requests, PC tracking queue,
// registered output FIFO to decode, redirect flush with drop counting.
module if_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            arst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  if_fetch_unit_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic            err;
  } fetch_entry_t;

  logic [XLEN-1:0]            fetch_pc;
  logic                       fetch_en;
  logic [CW-1:0]              inflight;
  logic [CW-1:0]              drop_cnt;
  logic [CW-1:0]              fifo_cnt;
  logic [DEPTH-1:0][XLEN-1:0] trk_q;
  logic [PW-1:0]              trk_wptr, trk_rptr;
  fetch_entry_t [DEPTH-1:0]   fifo_q;
  logic [PW-1:0]              fifo_wptr, fifo_rptr;

  logic [CW:0]  occupancy;
  logic         credit;
  logic         req_fire;
  logic         rsp_ok;
  logic         rsp_keep;
  logic         rsp_drop;
  logic         pop;
  fetch_entry_t push_entry;

  // Every accepted request owns a FIFO slot, so responses never need backpressure.
  assign occupancy = {1'b0, inflight} + {1'b0, fifo_cnt};
  assign credit    = occupancy < (CW+1)'(DEPTH);

  assign bus.imem_req_valid = fetch_en && credit && !redirect_valid && (drop_cnt == '0);
  assign bus.imem_req_addr  = fetch_pc;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

  // A response with nothing outstanding is ignored rather than corrupting the counters.
  assign rsp_ok   = bus.imem_rsp_valid && (inflight != '0);
  assign rsp_keep = rsp_ok && !redirect_valid && (drop_cnt == '0);
  assign rsp_drop = rsp_ok && !redirect_valid && (drop_cnt != '0);
  assign pop      = bus.if_valid && bus.if_ready && !redirect_valid;

  assign push_entry = fetch_entry_t'{
    pc:    trk_q[trk_rptr],
    instr: bus.imem_rsp_data,
    err:   bus.imem_rsp_err
  };

  assign bus.if_valid = (fifo_cnt != '0);
  assign bus.if_pc    = fifo_q[fifo_rptr].pc;
  assign bus.if_instr = fifo_q[fifo_rptr].instr;
  assign bus.if_err   = fifo_q[fifo_rptr].err;

  // fetch_en keeps the request channel quiet while reset is held and for the
  // first edge after release.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      fetch_pc  <= RESET_PC;
      fetch_en  <= 1'b0;
      inflight  <= '0;
      drop_cnt  <= '0;
      fifo_cnt  <= '0;
      trk_wptr  <= '0;
      trk_rptr  <= '0;
      fifo_wptr <= '0;
      fifo_rptr <= '0;
    end else begin
      fetch_en <= 1'b1;
      if (redirect_valid) begin
        // Outstanding requests become drops; a response arriving now is one of them.
        fetch_pc  <= {redirect_pc[XLEN-1:2], 2'b00};
        inflight  <= inflight - CW'(rsp_ok);
        drop_cnt  <= inflight - CW'(rsp_ok);
        fifo_cnt  <= '0;
        trk_wptr  <= '0;
        trk_rptr  <= '0;
        fifo_wptr <= '0;
        fifo_rptr <= '0;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
        inflight <= inflight + CW'(req_fire) - CW'(rsp_ok);
        if (rsp_drop) drop_cnt <= drop_cnt - CW'(1);
        if (req_fire) trk_wptr <= trk_wptr + PW'(1);
        // Dropped responses have no tracking entry: the queue was flushed with them.
        if (rsp_keep) trk_rptr <= trk_rptr + PW'(1);
        if (rsp_keep) fifo_wptr <= fifo_wptr + PW'(1);
        if (pop) fifo_rptr <= fifo_rptr + PW'(1);
        fifo_cnt <= fifo_cnt + CW'(rsp_keep) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      trk_q  <= '0;
      fifo_q <= '0;
    end else begin
      if (req_fire) trk_q[trk_wptr] <= fetch_pc;
      if (rsp_keep) fifo_q[fifo_wptr] <= push_entry;
    end
  end

  a_rsp_needs_inflight: assert property (
    @(posedge clk) disable iff (!arst_n) bus.imem_rsp_valid |-> (inflight != '0)
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized scoreboard bench for if_fetch_unit: a behavioural memory and PC model
// predicts the request address stream and the instruction stream seen by decode.
module tb_if_fetch_unit;
  logic        clk = 1'b0;
  logic        arst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redir1_valid;
  logic [31:0] redir1_pc;

  always #5 clk = ~clk;

  if_fetch_unit_if #(.XLEN(32)) bus0();
  if_fetch_unit_if #(.XLEN(32)) bus1();

  if_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .DEPTH(2)) u_dut0 (
    .clk(clk), .arst_n(arst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .bus(bus0)
  );

  if_fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .DEPTH(2)) u_dut1 (
    .clk(clk), .arst_n(arst_n),
    .redirect_valid(redir1_valid), .redirect_pc(redir1_pc),
    .bus(bus1)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        err;
  } exp_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_req = 0;
  int dead = 0;
  int req_budget = -1;
  int unsigned p_req_rdy = 0, p_rsp = 0, p_ifrdy = 0, p_redir = 0, lat_extra = 0;
  bit          force_redir = 1'b0, force_rsp = 1'b0;
  logic [31:0] force_pc = '0;
  logic [31:0] exp_pc = '0;
  logic [31:0] mem_q[$];
  int          mem_due[$];
  logic [31:0] live[$];
  exp_t        expq[$];
  exp_t        mon_e;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  function automatic logic err_of(input logic [31:0] a);
    return a[6:2] == 5'd7;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory and redirect/decode stimulus, applied just after each rising edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (!arst_n) begin
      bus0.imem_req_ready = 1'b0;
      bus0.imem_rsp_valid = 1'b0;
      bus0.imem_rsp_data  = '0;
      bus0.imem_rsp_err   = 1'b0;
      bus0.if_ready       = 1'b0;
      redirect_valid      = 1'b0;
    end else begin
      bus0.imem_req_ready = (req_budget != 0) && ($urandom_range(99) < p_req_rdy);
      if (mem_q.size() > 0 && (force_rsp || (mem_due[0] <= cyc && $urandom_range(99) < p_rsp))) begin
        bus0.imem_rsp_valid = 1'b1;
        bus0.imem_rsp_data  = instr_of(mem_q[0]);
        bus0.imem_rsp_err   = err_of(mem_q[0]);
        void'(mem_q.pop_front());
        void'(mem_due.pop_front());
      end else begin
        bus0.imem_rsp_valid = 1'b0;
        bus0.imem_rsp_data  = $urandom;
        bus0.imem_rsp_err   = 1'($urandom_range(1));
      end
      force_rsp     = 1'b0;
      bus0.if_ready = $urandom_range(99) < p_ifrdy;
      if (force_redir) begin
        redirect_valid = 1'b1;
        redirect_pc    = force_pc;
        force_redir    = 1'b0;
      end else if ($urandom_range(99) < p_redir) begin
        redirect_valid = 1'b1;
        redirect_pc    = ($urandom_range(3) == 0) ? 32'hFFFF_FFF4 + 32'($urandom_range(7)) : $urandom;
      end else begin
        redirect_valid = 1'b0;
      end
    end
  end

  // Reference model: what the fetch unit should request and deliver, in program order.
  always @(negedge clk) begin
    if (arst_n) begin
      if (redirect_valid) begin
        chk("redirect_no_req", {31'b0, bus0.imem_req_valid}, 32'd0);
        dead += live.size();
        live.delete();
        expq.delete();
        exp_pc = {redirect_pc[31:2], 2'b00};
      end
      if (bus0.imem_rsp_valid) begin
        if (dead > 0) dead--;
        else if (live.size() > 0) begin
          logic [31:0] a;
          a = live.pop_front();
          expq.push_back(exp_t'{pc: a, instr: instr_of(a), err: err_of(a)});
        end
      end
      if (bus0.imem_req_valid && bus0.imem_req_ready) begin
        chk("req_addr", bus0.imem_req_addr, exp_pc);
        live.push_back(exp_pc);
        mem_q.push_back(bus0.imem_req_addr);
        mem_due.push_back(cyc + 1 + int'($urandom_range(lat_extra)));
        exp_pc = exp_pc + 32'd4;
        if (req_budget > 0) req_budget--;
        n_req++;
      end
    end
  end

  // Decode-side monitor: every accepted instruction must match the scoreboard head.
  always @(negedge clk) begin
    if (arst_n && bus0.if_valid && bus0.if_ready && !redirect_valid) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL if_unexpected: got pc 0x%08h expected no instruction", bus0.if_pc);
      end else begin
        mon_e = expq.pop_front();
        chk("if_pc", bus0.if_pc, mon_e.pc);
        chk("if_instr", bus0.if_instr, mon_e.instr);
        chk("if_err", {31'b0, bus0.if_err}, {31'b0, mon_e.err});
      end
    end
  end

  task automatic do_redirect(input logic [31:0] pc, input bit with_rsp);
    force_pc    = pc;
    force_redir = 1'b1;
    force_rsp   = with_rsp;
    @(negedge clk); #1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    p_req_rdy = 0; p_redir = 0; p_rsp = 100; p_ifrdy = 100;
    n = 0;
    while ((mem_q.size() != 0 || expq.size() != 0 || dead != 0 || bus0.if_valid) && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL %s: got still busy after %0d cycles expected idle", name, n);
    end
  endtask

  initial begin
    int n;
    arst_n = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    redir1_valid = 1'b0;   redir1_pc = '0;
    bus0.imem_req_ready = 1'b0; bus0.imem_rsp_valid = 1'b0;
    bus0.imem_rsp_data = '0;    bus0.imem_rsp_err = 1'b0; bus0.if_ready = 1'b0;
    bus1.imem_req_ready = 1'b0; bus1.imem_rsp_valid = 1'b0;
    bus1.imem_rsp_data = '0;    bus1.imem_rsp_err = 1'b0; bus1.if_ready = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_valid", {31'b0, bus0.imem_req_valid}, 32'd0);
    chk("rst_req_addr", bus0.imem_req_addr, 32'h0);
    chk("rst_if_valid", {31'b0, bus0.if_valid}, 32'd0);
    chk("rst_if_pc", bus0.if_pc, 32'h0);
    chk("rst_if_instr", bus0.if_instr, 32'h0);
    chk("rst_if_err", {31'b0, bus0.if_err}, 32'd0);
    chk("rst1_req_valid", {31'b0, bus1.imem_req_valid}, 32'd0);
    chk("rst1_req_addr", bus1.imem_req_addr, 32'hFFFF_FFFC);
    #1 arst_n = 1'b1;

    // High reset PC wraps to zero; a faulting response keeps its PC.
    @(negedge clk);
    chk("wrap_first_valid", {31'b0, bus1.imem_req_valid}, 32'd1);
    chk("wrap_first_addr", bus1.imem_req_addr, 32'hFFFF_FFFC);
    bus1.imem_req_ready = 1'b1;
    @(negedge clk);
    chk("wrap_next_valid", {31'b0, bus1.imem_req_valid}, 32'd1);
    chk("wrap_next_addr", bus1.imem_req_addr, 32'h0000_0000);
    bus1.imem_req_ready = 1'b0;
    bus1.imem_rsp_valid = 1'b1; bus1.imem_rsp_data = 32'h0000_0073; bus1.imem_rsp_err = 1'b1;
    @(negedge clk);
    bus1.imem_rsp_valid = 1'b0; bus1.imem_rsp_err = 1'b0;
    chk("err_if_valid", {31'b0, bus1.if_valid}, 32'd1);
    chk("err_if_pc", bus1.if_pc, 32'hFFFF_FFFC);
    chk("err_if_instr", bus1.if_instr, 32'h0000_0073);
    chk("err_if_err", {31'b0, bus1.if_err}, 32'd1);

    // Decode stalled: only DEPTH requests may go out.
    n_req = 0; p_req_rdy = 100; p_rsp = 100; p_ifrdy = 0; lat_extra = 0;
    repeat (12) @(negedge clk);
    #1;
    chk("stall_req_count", 32'(n_req), 32'd2);
    chk("stall_req_valid", {31'b0, bus0.imem_req_valid}, 32'd0);
    chk("stall_if_valid", {31'b0, bus0.if_valid}, 32'd1);
    chk("stall_if_pc", bus0.if_pc, 32'h0);
    chk("stall_if_instr", bus0.if_instr, instr_of(32'h0));

    // Streaming resumes at 0x8, then a redirect that wraps the address space.
    p_ifrdy = 100;
    repeat (40) @(negedge clk);
    #1;
    do_redirect(32'hFFFF_FFF9, 1'b0);
    repeat (20) @(negedge clk);
    #1;

    // Redirect with two requests held in memory: both must be discarded.
    p_rsp = 0;
    repeat (8) @(negedge clk);
    #1;
    chk("pre_redir_outstanding", 32'(mem_q.size()), 32'd2);
    chk("pre_redir_if_valid", {31'b0, bus0.if_valid}, 32'd0);
    do_redirect(32'h0000_1002, 1'b0);
    @(negedge clk);
    chk("drop_req_valid", {31'b0, bus0.imem_req_valid}, 32'd0);
    chk("drop_if_valid", {31'b0, bus0.if_valid}, 32'd0);
    #1 p_rsp = 100;
    repeat (20) @(negedge clk);
    #1;

    // Redirect coinciding with the only outstanding response.
    wait_idle("idle_before_single");
    p_rsp = 0; p_ifrdy = 100; req_budget = 1; p_req_rdy = 100;
    n = 0;
    while (req_budget != 0 && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    chk("single_req_issued", 32'(req_budget), 32'd0);
    do_redirect(32'h0000_2000, 1'b1);
    @(negedge clk);
    chk("same_cycle_req_valid", {31'b0, bus0.imem_req_valid}, 32'd1);
    chk("same_cycle_req_addr", bus0.imem_req_addr, 32'h0000_2000);
    #1 req_budget = -1; p_rsp = 100;
    repeat (20) @(negedge clk);
    #1;

    // Randomized traffic with occasional redirects.
    for (int seg = 0; seg < 6; seg++) begin
      p_req_rdy = $urandom_range(100, 30);
      p_rsp     = $urandom_range(100, 30);
      p_ifrdy   = $urandom_range(100, 20);
      p_redir   = $urandom_range(6);
      lat_extra = $urandom_range(2);
      repeat (500) @(negedge clk);
      #1;
    end

    // Asynchronous reset with a full FIFO.
    wait_idle("idle_before_reset");
    lat_extra = 0; p_req_rdy = 100; p_rsp = 100; p_ifrdy = 0;
    repeat (8) @(negedge clk);
    chk("prereset_if_valid", {31'b0, bus0.if_valid}, 32'd1);
    #2 arst_n = 1'b0;
    #1;
    chk("arst_req_valid", {31'b0, bus0.imem_req_valid}, 32'd0);
    chk("arst_if_valid", {31'b0, bus0.if_valid}, 32'd0);
    chk("arst_if_pc", bus0.if_pc, 32'h0);
    chk("arst_if_instr", bus0.if_instr, 32'h0);
    chk("arst_if_err", {31'b0, bus0.if_err}, 32'd0);
    mem_q.delete(); mem_due.delete(); live.delete(); expq.delete();
    dead = 0; exp_pc = 32'h0;
    @(negedge clk);
    #2 arst_n = 1'b1;
    p_ifrdy = 100;
    @(negedge clk);
    chk("post_reset_req_valid", {31'b0, bus0.imem_req_valid}, 32'd1);
    chk("post_reset_req_addr", bus0.imem_req_addr, 32'h0);
    repeat (30) @(negedge clk);
    #1;

    wait_idle("final_drain");
    chk("final_if_valid", {31'b0, bus0.if_valid}, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
